// File: rtl/urv_iram_loader.sv
// Byte-stream command loader for the uRV instruction/data RAM.
// It writes and reads 32-bit words over one RAM port and holds the core in reset while code is loaded.
module urv_iram_loader #(
  parameter int g_size     = 65536,
  parameter int g_timeout  = 1000000,
  parameter int g_hold_cpu = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_bwe_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_q_i,
  output logic        cpu_rst_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_CNT, S_WDATA, S_WRITE, S_RESP, S_RACC, S_RLAT, S_RSEND
  } state_t;

  localparam logic [31:0] ADDR_MASK = 32'(g_size - 1) & 32'hFFFF_FFFC;
  localparam logic [31:0] TMO_LAST  = 32'(g_timeout - 1);
  localparam bit          TMO_EN    = (g_timeout != 0);
  localparam logic [7:0]  C_WRITE   = 8'h57;
  localparam logic [7:0]  C_READ    = 8'h52;
  localparam logic [7:0]  C_HALT    = 8'h48;
  localparam logic [7:0]  C_GO      = 8'h47;
  localparam logic [7:0]  C_OK      = 8'h4B;
  localparam logic [7:0]  C_ERR     = 8'h45;

  state_t      r_state, w_state_next;
  logic        r_alive;
  logic        r_cpu_rst;
  logic [7:0]  r_cmd;
  logic [7:0]  r_resp;
  logic [7:0]  r_wcnt;
  logic [1:0]  r_bcnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_shift;
  logic [31:0] r_tmo;

  logic        w_rx_ready, w_rx_fire, w_tx_valid, w_tx_fire, w_tmo_hit, w_rx_state;
  logic [31:0] w_addr, w_addr_inc;

  assign w_addr     = r_addr & ADDR_MASK;
  assign w_addr_inc = (w_addr + 32'd4) & ADDR_MASK;
  assign w_rx_state = (r_state == S_ADDR) || (r_state == S_CNT) || (r_state == S_WDATA);
  assign w_rx_ready = r_alive && ((r_state == S_IDLE) || w_rx_state);
  assign w_rx_fire  = rx_valid_i && w_rx_ready;
  assign w_tx_valid = (r_state == S_RESP) || (r_state == S_RSEND);
  assign w_tx_fire  = w_tx_valid && tx_ready_i;
  assign w_tmo_hit  = TMO_EN && w_rx_state && !w_rx_fire && (r_tmo == TMO_LAST);

  assign rx_ready_o = w_rx_ready;
  assign tx_valid_o = w_tx_valid;
  assign tx_data_o  = (r_state == S_RSEND) ? r_shift[31:24] :
                      (r_state == S_RESP)  ? r_resp : 8'h00;
  assign mem_en_o   = (r_state == S_WRITE) || (r_state == S_RACC);
  assign mem_we_o   = (r_state == S_WRITE);
  assign mem_bwe_o  = (r_state == S_WRITE) ? 4'hF : 4'h0;
  assign mem_addr_o = w_addr;
  assign mem_data_o = (r_state == S_WRITE) ? r_wdata : 32'h0;
  assign cpu_rst_o  = r_cpu_rst;
  assign busy_o     = (r_state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rx_fire) w_state_next = S_CMD;
      S_CMD:   w_state_next = (r_cmd == C_WRITE || r_cmd == C_READ) ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (w_tmo_hit) w_state_next = S_IDLE;
        else if (w_rx_fire && r_bcnt == 2'd3) w_state_next = S_CNT;
      end
      S_CNT: begin
        if (w_tmo_hit) w_state_next = S_IDLE;
        else if (w_rx_fire) w_state_next = (r_cmd == C_WRITE) ? S_WDATA : S_RACC;
      end
      S_WDATA: begin
        if (w_tmo_hit) w_state_next = S_IDLE;
        else if (w_rx_fire && r_bcnt == 2'd3) w_state_next = S_WRITE;
      end
      S_WRITE: w_state_next = (r_wcnt == 8'd0) ? S_RESP : S_WDATA;
      S_RESP:  if (w_tx_fire) w_state_next = S_IDLE;
      S_RACC:  w_state_next = S_RLAT;
      S_RLAT:  w_state_next = S_RSEND;
      S_RSEND: begin
        if (w_tx_fire && r_bcnt == 2'd3) w_state_next = (r_wcnt == 8'd0) ? S_IDLE : S_RACC;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_alive   <= 1'b0;
      r_cpu_rst <= (g_hold_cpu != 0);
      r_cmd     <= 8'h00;
      r_resp    <= 8'h00;
      r_wcnt    <= 8'h00;
      r_bcnt    <= 2'd0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_shift   <= 32'h0;
      r_tmo     <= 32'h0;
    end else begin
      r_alive <= 1'b1;
      // Idle-gap timer; any accepted byte or leaving the receive states restarts it.
      if (w_rx_state && !w_rx_fire) r_tmo <= r_tmo + 32'd1;
      else                          r_tmo <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_cmd  <= rx_data_i;
            r_bcnt <= 2'd0;
            if (rx_data_i == C_WRITE || rx_data_i == C_READ) r_cpu_rst <= 1'b1;
          end
        end
        S_CMD: begin
          r_resp <= C_ERR;
          if (r_cmd == C_HALT) begin
            r_cpu_rst <= 1'b1;
            r_resp    <= C_OK;
          end else if (r_cmd == C_GO) begin
            r_cpu_rst <= 1'b0;
            r_resp    <= C_OK;
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {r_addr[23:0], rx_data_i};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_CNT: begin
          if (w_rx_fire) begin
            r_wcnt <= rx_data_i;
            r_bcnt <= 2'd0;
          end
        end
        S_WDATA: begin
          if (w_rx_fire) begin
            r_wdata <= {r_wdata[23:0], rx_data_i};
            r_bcnt  <= r_bcnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_addr <= w_addr_inc;
          if (r_wcnt != 8'd0) r_wcnt <= r_wcnt - 8'd1;
          else                r_resp <= C_OK;
        end
        S_RLAT: r_shift <= mem_q_i;
        S_RSEND: begin
          if (w_tx_fire) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_addr <= w_addr_inc;
              if (r_wcnt != 8'd0) r_wcnt <= r_wcnt - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
